// File: rtl/ucode_sequencer.sv
// ---------------------------------------------------------------------------
// ucode_sequencer
//
// Microcode sequencer that sits directly upstream of the control-store ROM.
// A start request latches a base address and a word count. The sequencer then
// walks consecutive ROM addresses and drives the ROM enable and address pins.
// Each registered ROM word is presented to the datapath through a valid/ready
// handshake. While ready stays high, one word is delivered per cycle.
//
// During a stall the ROM enable is held low, so the registered ROM output, and
// therefore ctrl_word, holds its value without an extra buffer register.
//
// Ports
//   clk         in   clock; every state update happens on the rising edge
//   rst_n       in   synchronous, active-low reset
//   start       in   one-cycle run request; only looked at while idle
//   start_addr  in   first ROM address of the run
//   count       in   number of words in the run minus one
//   abort       in   cancels the current run; wins over everything but reset
//   rom_en      out  ROM read enable
//   rom_addr    out  ROM read address (the fetch pointer)
//   rom_data    in   registered ROM output, valid one cycle after rom_en
//   ctrl_word   out  control word to the datapath (rom_data passthrough)
//   ctrl_valid  out  ctrl_word is valid
//   ctrl_ready  in   datapath accepts ctrl_word this cycle
//   ctrl_addr   out  ROM address of the word currently on ctrl_word
//   busy        out  a run is in progress
//   done        out  one-cycle pulse after the last word has been accepted
// ---------------------------------------------------------------------------
module ucode_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              abort,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ctrl_word,
  output logic              ctrl_valid,
  input  logic              ctrl_ready,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] rem;
  logic              last_word;
  logic              load_run;
  logic              advance;

  assign last_word = (rem == '0);

  // State register. Reset is synchronous, so it is sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. An abort from any active state returns straight to IDLE
  // without passing through DONE, so no done pulse is produced. A start that
  // arrives together with abort while idle is dropped.
  always_comb begin
    state_nxt = state;
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start && !abort) state_nxt = FETCH;
        FETCH:   state_nxt = ISSUE;
        ISSUE:   if (ctrl_ready && last_word) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode. In ISSUE, the next fetch is issued only when the current
  // word is being accepted. This keeps the ROM register, and therefore
  // ctrl_word, frozen during a stall. The pointer only advances on a fetch
  // that is not cancelled by abort.
  always_comb begin
    rom_en     = 1'b0;
    ctrl_valid = 1'b0;
    done       = 1'b0;
    load_run   = 1'b0;
    unique case (state)
      IDLE:    load_run = start && !abort;
      FETCH:   rom_en = 1'b1;
      ISSUE: begin
        ctrl_valid = 1'b1;
        rom_en     = ctrl_ready && !last_word;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    advance = rom_en && !abort;
  end

  // Run bookkeeping. ptr is the next address to fetch and wraps naturally at
  // 2^ADDR_W. ctrl_addr captures the address of each fetch, so it lines up
  // with the word that comes back from the ROM one cycle later. rem counts
  // down only for fetches made in ISSUE, because the FETCH-state read is the
  // word already accounted for by count being "length minus one".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      rem       <= '0;
      ctrl_addr <= '0;
    end else if (load_run) begin
      ptr <= start_addr;
      rem <= count;
    end else if (advance) begin
      ptr       <= ptr + ADDR_W'(1);
      ctrl_addr <= ptr;
      if (state == ISSUE) begin
        rem <= rem - ADDR_W'(1);
      end
    end
  end

  assign rom_addr  = ptr;
  assign ctrl_word = rom_data;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ucode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ucode_sequencer
//
// Drives ucode_sequencer against a registered control-store ROM model.
// Every word the sequencer will deliver is queued (data and address) when a
// run is started. The word is then popped and compared each time the
// datapath side accepts one.
// ---------------------------------------------------------------------------
module tb_ucode_sequencer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] count;
  logic              abort;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] ctrl_word;
  logic              ctrl_valid;
  logic              ctrl_ready;
  logic [ADDR_W-1:0] ctrl_addr;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t              expQ[$];
  logic [DATA_W-1:0] rom [256];
  logic [DATA_W-1:0] romQ;
  int                checks = 0;
  int                failures = 0;
  int                doneCount = 0;
  int                d0;

  always #5 clk = ~clk;

  ucode_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .abort      (abort),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ctrl_word  (ctrl_word),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .ctrl_addr  (ctrl_addr),
    .busy       (busy),
    .done       (done)
  );

  // Registered control-store ROM: the output updates only on enabled reads.
  always @(posedge clk) begin
    if (rom_en) romQ <= rom[rom_addr];
  end
  assign rom_data = romQ;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Starts a run and queues the words that the bench expects to be accepted.
  // Returns one tick after the edge that samples start, i.e. in the FETCH cycle.
  task automatic applyStimulus(input logic [ADDR_W-1:0] sa,
                               input logic [ADDR_W-1:0] cnt, input int nAcc);
    exp_t e;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < nAcc; i++) begin
      a      = sa + ADDR_W'(i);
      e.word = rom[a];
      e.addr = a;
      expQ.push_back(e);
    end
    @(posedge clk); #1;
    start_addr = sa;
    count      = cnt;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < maxCycles) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) doneCount++;
    if (rst_n && ctrl_valid && !ctrl_ready)
      checkOutput("stall_rom_en", 32'(rom_en), 32'd0);
    if (rst_n && ctrl_valid && ctrl_ready && !abort) begin
      checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("word", 32'(ctrl_word), 32'(e.word));
        checkOutput("ctrl_addr", 32'(ctrl_addr), 32'(e.addr));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = {8'(a) ^ 8'hA5, 8'(a) ^ 8'h3C};
    rom[3] = 16'h0008;
    rom[4] = 16'h0004;
    rom[5] = 16'h0002;
    rom[6] = 16'h0010;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ctrl_ready = 1'b1;
    start_addr = '0; count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rom_en", 32'(rom_en), 32'd0);
    checkOutput("rst_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("rst_ctrl_addr", 32'(ctrl_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T1: four words back to back, then exact latency checks.
    d0 = doneCount;
    applyStimulus(8'h03, 8'd3, 4);
    @(negedge clk);
    checkOutput("t1_fetch_en", 32'(rom_en), 32'd1);
    checkOutput("t1_fetch_addr", 32'(rom_addr), 32'h03);
    checkOutput("t1_fetch_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("t1_fetch_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t1_valid", 32'(ctrl_valid), 32'd1);
    end
    @(negedge clk);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_done_valid", 32'(ctrl_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);
    checkOutput("t1_idle_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_done_pulses", 32'(doneCount - d0), 32'd1);
    checkOutput("t1_sb_empty", 32'(expQ.size()), 32'd0);

    // T2: stall for three cycles while the second word is shown.
    applyStimulus(8'h03, 8'd3, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ctrl_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t2_hold_word", 32'(ctrl_word), 32'h0004);
      checkOutput("t2_hold_valid", 32'(ctrl_valid), 32'd1);
      @(posedge clk); #1;
    end
    ctrl_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2_resume_word", 32'(ctrl_word), 32'h0004);
    waitDone("t2_done", 10);
    @(posedge clk); #1;
    checkOutput("t2_sb_empty", 32'(expQ.size()), 32'd0);

    // T3: address wrap-around.
    applyStimulus(8'hFE, 8'd2, 3);
    @(negedge clk);
    checkOutput("t3_addr_fe", 32'(rom_addr), 32'hFE);
    @(negedge clk);
    checkOutput("t3_addr_ff", 32'(rom_addr), 32'hFF);
    checkOutput("t3_en_ff", 32'(rom_en), 32'd1);
    @(negedge clk);
    checkOutput("t3_addr_00", 32'(rom_addr), 32'h00);
    checkOutput("t3_en_00", 32'(rom_en), 32'd1);
    @(negedge clk);
    checkOutput("t3_last_en", 32'(rom_en), 32'd0);
    waitDone("t3_done", 10);
    @(posedge clk); #1;
    checkOutput("t3_sb_empty", 32'(expQ.size()), 32'd0);

    // T4: abort on the third word, then a normal run.
    d0 = doneCount;
    applyStimulus(8'h20, 8'd10, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    checkOutput("t4_third_valid", 32'(ctrl_valid), 32'd1);
    checkOutput("t4_third_word", 32'(ctrl_word), 32'(rom[8'h22]));
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("t4_abort_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("t4_abort_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t4_no_done", 32'(doneCount - d0), 32'd0);
    checkOutput("t4_sb_empty", 32'(expQ.size()), 32'd0);
    applyStimulus(8'h10, 8'd1, 2);
    waitDone("t4_rerun_done", 10);
    @(posedge clk); #1;
    checkOutput("t4_rerun_sb_empty", 32'(expQ.size()), 32'd0);

    // T5: synchronous reset in the middle of a run.
    applyStimulus(8'h0B, 8'd5, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_rom_en", 32'(rom_en), 32'd0);
    checkOutput("t5_valid", 32'(ctrl_valid), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_sb_empty", 32'(expQ.size()), 32'd0);

    // When start and abort arrive together in IDLE, start is ignored.
    @(posedge clk); #1;
    start_addr = 8'h40; count = 8'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checkOutput("idle_abort_start_busy", 32'(busy), 32'd0);

    // T6: a start pulse during a run is ignored; a count=0 run delivers one word.
    applyStimulus(8'h03, 8'd3, 4);
    @(posedge clk); #1;
    start_addr = 8'h40; count = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone("t6_done", 10);
    @(posedge clk); #1;
    checkOutput("t6_sb_empty", 32'(expQ.size()), 32'd0);
    applyStimulus(8'h05, 8'd0, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_single_valid", 32'(ctrl_valid), 32'd1);
    @(negedge clk);
    checkOutput("t6_single_done", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("t6_single_idle", 32'(busy), 32'd0);
    checkOutput("t6_single_sb_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
